booth_seq_multiplier: RTL
=========================

// Module: booth_seq_multiplier
// PURPOSE
//  Parametrised iterative Booth multiplier with valid/ready handshakes on input and output.
//  Supports signed and unsigned operands, selected per operation.
//  Operand and product registers are internal: accept once, compute over several cycles, hold until consumed.
//  Sits between operand-producing datapath stages and a result consumer in the multiplier subsystem.
// PARAMETERS
//  WIDTH  32  operand width in bits; even, >= 4; product is 2*WIDTH
// PORTS
//  clk         in   1        rising-edge clock (single clock domain)
//  resetN      in   1        asynchronous, active-low reset
//  inValid     in   1        operands a/b/signedMode valid
//  inReady     out  1        block can accept operands (high only in IDLE)
//  a           in   WIDTH    multiplicand
//  b           in   WIDTH    multiplier
//  signedMode  in   1        1: two's-complement operands; 0: unsigned
//  outValid    out  1        product valid (high only in DONE)
//  outReady    in   1        consumer takes product
//  product     out  2*WIDTH  result, registered
//  busy        out  1        high in CALC or DONE
// BEHAVIOUR
//  Reset (async, resetN=0): state=IDLE, inReady=1, outValid=0, busy=0, product=0, counter=0.
//  Reset mid-operation aborts immediately; no partial result is ever presented.
//  Extension: operands sign-extended (signedMode=1) or zero-extended (0) to E=WIDTH+2 bits at accept.
//  ITER = E (radix-2) or E/2 (radix-4, see CONFIGURATION).
//  FSM states IDLE, CALC, DONE; inReady/outValid/busy decode directly from registered state.
//  IDLE: on edge with inValid&inReady, capture a, b, signedMode.
//    Clear accumulator, set Booth guard bit q[-1]=0, counter=ITER, go CALC.
//  CALC: one Booth step per cycle on {acc,q,q[-1]}; acc is E+2 bits.
//    Radix-2 step: examine {q0,q[-1]}: 01 add M, 10 sub M, 00/11 none; then arithmetic shift right 1.
//    counter decrements each step. Step with counter==1 writes product=low 2*WIDTH bits of {acc,q}.
//    That step goes to DONE.
//  Latency: outValid rises exactly ITER cycles after the accept edge.
//  DONE: product and outValid held stable until outReady=1; that edge goes to IDLE.
//    inReady=1 the following cycle. Min issue interval = ITER+2 cycles.
//  inValid ignored outside IDLE; a/b changes after accept have no effect.
//  outReady ignored outside DONE.
//  product keeps last result in IDLE/CALC until overwritten by the next completion.
//  Arithmetic: exact 2*WIDTH-bit result for all inputs, incl. signed MIN*MIN and unsigned MAX*MAX; no overflow flag.
// CONFIGURATION
//  BOOTH_RADIX4_EN defined: radix-4 (modified Booth) recoding.
//    Examine {q1,q0,q[-1]}: 000/111 0, 001/010 +M, 011 +2M, 100 -2M, 101/110 -M.
//    Then arithmetic shift right 2. ITER=E/2 (WIDTH=32: 17 cycles).
//  Undefined: radix-2 as above, ITER=E (WIDTH=32: 34 cycles).
//  Handshake, reset and result values identical in both builds; only latency differs.
// TESTING  (WIDTH=32; L=34 radix-2, 17 with BOOTH_RADIX4_EN; run both builds)
//  1. signed 5 x 6, outReady=1 -> product=64'd30 exactly L cycles after accept; inReady low during CALC/DONE.
//  2. signed -4x-7 -> 64'd28.
//     signed 10x-4 -> 64'hFFFF_FFFF_FFFF_FFD8.
//     signed 0x80000000^2 -> 64'h4000_0000_0000_0000.
//  3. unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001.
//     The same operands signed -> 64'd1.
//  4. Backpressure: 1234 x 0 with outReady=0 for 10 cycles -> outValid/product=0 stable.
//     a/b/inValid toggling ignored; outReady pulse -> IDLE next cycle.
//  5. resetN low for 1 cycle mid-CALC (99 x 1) -> outputs at reset values immediately.
//     Then 32 x 23 -> 64'd736 with full latency L.
//  6. WIDTH=8 instance: exhaustive 256x256 pairs in both modes, each checked vs $signed/$unsigned model.
//     Back-to-back issue every ITER+2 cycles.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// Iterative Booth multiplier (signed/unsigned per operation) with valid/ready on both sides.
// Define BOOTH_RADIX4_EN for modified-Booth radix-4 recoding (half the iterations); default is radix-2.
module booth_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               inValid,
   output logic               inReady,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signedMode,
   output logic               outValid,
   input  logic               outReady,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam int E  = WIDTH + 2;
   localparam int AW = E + 2;
`ifdef BOOTH_RADIX4_EN
   localparam int ITER = E / 2;
`else
   localparam int ITER = E;
`endif
   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t r_state, w_state_nxt;

   logic signed [AW-1:0]  r_acc;
   logic signed [AW-1:0]  r_m;
   logic [E-1:0]          r_q;
   logic                  r_qm1;
   logic [CW-1:0]         r_cnt;
   logic [2*WIDTH-1:0]    r_product;

   logic                  w_accept;
   logic                  w_last;
   logic signed [AW-1:0]  w_addend;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_acc_nxt;
   logic [E-1:0]          w_q_nxt;
   logic                  w_qm1_nxt;

   assign inReady  = (r_state == IDLE);
   assign outValid = (r_state == DONE);
   assign busy     = (r_state != IDLE);
   assign product  = r_product;

   assign w_accept = inReady && inValid;
   assign w_last   = (r_cnt == CW'(1));

   // Booth recoding of the low multiplier bits plus guard bit
   always_comb begin
      w_addend = '0;
`ifdef BOOTH_RADIX4_EN
      case ({r_q[1:0], r_qm1})
         3'b001, 3'b010: w_addend = r_m;
         3'b011:         w_addend = r_m <<< 1;
         3'b100:         w_addend = -(r_m <<< 1);
         3'b101, 3'b110: w_addend = -r_m;
         default:        w_addend = '0;
      endcase
`else
      case ({r_q[0], r_qm1})
         2'b01:   w_addend = r_m;
         2'b10:   w_addend = -r_m;
         default: w_addend = '0;
      endcase
`endif
   end

   assign w_sum = r_acc + w_addend;

`ifdef BOOTH_RADIX4_EN
   assign w_acc_nxt = w_sum >>> 2;
   assign w_q_nxt   = {w_sum[1:0], r_q[E-1:2]};
   assign w_qm1_nxt = r_q[1];
`else
   assign w_acc_nxt = w_sum >>> 1;
   assign w_q_nxt   = {w_sum[0], r_q[E-1:1]};
   assign w_qm1_nxt = r_q[0];
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (inValid)  w_state_nxt = CALC;
         CALC:    if (w_last)   w_state_nxt = DONE;
         DONE:    if (outReady) w_state_nxt = IDLE;
         default:               w_state_nxt = IDLE;
      endcase
   end

   // Operands are widened by two bits so unsigned MAX and signed MIN both multiply exactly
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_acc     <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_qm1     <= 1'b0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
         r_m   <= {{(AW-WIDTH){signedMode & a[WIDTH-1]}}, a};
         r_q   <= {{2{signedMode & b[WIDTH-1]}}, b};
         r_qm1 <= 1'b0;
         r_cnt <= CW'(ITER);
      end else if (r_state == CALC) begin
         r_acc <= w_acc_nxt;
         r_q   <= w_q_nxt;
         r_qm1 <= w_qm1_nxt;
         r_cnt <= r_cnt - CW'(1);
         if (w_last) r_product <= {w_acc_nxt[E-5:0], w_q_nxt};
      end
   end
endmodule
